// File: rtl/tri_raster_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : tri_raster_scan_if
// Description : Vertex-in / point-out bundle between the triangle source and
//               the raster scanner. The source is the master and the
//               scanner is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface tri_raster_scan_if #(
   parameter int CW = 3
);
   logic          nt;
   logic [CW-1:0] xi;
   logic [CW-1:0] yi;
   logic          busy;
   logic          po;
   logic [CW-1:0] xo;
   logic [CW-1:0] yo;

   modport master (output nt, xi, yi, input  busy, po, xo, yo);
   modport slave  (input  nt, xi, yi, output busy, po, xo, yo);
endinterface
`default_nettype wire

// File: rtl/tri_raster_scan.sv
`default_nettype none
// ============================================================================
// Module      : tri_raster_scan
// Description : Loads three vertices on consecutive cycles. It scans their
//               bounding box in raster order, one lattice point per cycle,
//               and flags each point that lies inside or on the triangle.
// Revision    : 1.0 - initial release
// ============================================================================
module tri_raster_scan #(
   parameter int CW = 3
) (
   input  logic             clk,
   input  logic             reset,
   tri_raster_scan_if.slave bus
);
   localparam int            PW    = 2*CW + 3;
   localparam logic [CW-1:0] c_ONE = CW'(1);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_LOAD_B = 3'd1;
   localparam logic [2:0] c_LOAD_C = 3'd2;
   localparam logic [2:0] c_SETUP  = 3'd3;
   localparam logic [2:0] c_SCAN   = 3'd4;
   localparam logic [2:0] c_DRAIN  = 3'd5;

   // Compute (b-a) x (p-a). The sign tells which side of edge a->b the point p lies on.
   function automatic logic signed [PW-1:0] f_edge(
      input logic [CW-1:0] ax, input logic [CW-1:0] ay,
      input logic [CW-1:0] bx, input logic [CW-1:0] by,
      input logic [CW-1:0] px, input logic [CW-1:0] py);
      logic signed [CW:0]   dxe, dye, dxp, dyp;
      logic signed [PW-1:0] m0, m1;
      dxe = $signed({1'b0, bx}) - $signed({1'b0, ax});
      dye = $signed({1'b0, by}) - $signed({1'b0, ay});
      dxp = $signed({1'b0, px}) - $signed({1'b0, ax});
      dyp = $signed({1'b0, py}) - $signed({1'b0, ay});
      m0  = PW'(dxe) * PW'(dyp);
      m1  = PW'(dye) * PW'(dxp);
      return m0 - m1;
   endfunction

   function automatic logic [CW-1:0] f_min3(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b,
                                            input logic [CW-1:0] c);
      logic [CW-1:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic logic [CW-1:0] f_max3(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b,
                                            input logic [CW-1:0] c);
      logic [CW-1:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   logic [2:0]           r_state;
   logic [2:0]           w_next;
   logic [CW-1:0]        r_ax, r_ay, r_bx, r_by, r_cx, r_cy;
   logic [CW-1:0]        r_xmin, r_xmax, r_ymin, r_ymax;
   logic [CW-1:0]        r_sx, r_sy;
   logic signed [PW-1:0] r_d;
   logic                 r_busy, r_po;
   logic [CW-1:0]        r_xo, r_yo;

   logic                 w_ld_a, w_ld_b, w_ld_c, w_setup, w_scan, w_drain;
   logic signed [PW-1:0] w_d, w_e0, w_e1, w_e2;
   logic [CW-1:0]        w_xmin, w_xmax, w_ymin, w_ymax;
   logic                 w_degen, w_last, w_ge0, w_le0, w_inside;

   assign w_d     = f_edge(r_ax, r_ay, r_bx, r_by, r_cx, r_cy);
   assign w_degen = (w_d == '0);
   assign w_xmin  = f_min3(r_ax, r_bx, r_cx);
   assign w_xmax  = f_max3(r_ax, r_bx, r_cx);
   assign w_ymin  = f_min3(r_ay, r_by, r_cy);
   assign w_ymax  = f_max3(r_ay, r_by, r_cy);

   assign w_e0    = f_edge(r_ax, r_ay, r_bx, r_by, r_sx, r_sy);
   assign w_e1    = f_edge(r_bx, r_by, r_cx, r_cy, r_sx, r_sy);
   assign w_e2    = f_edge(r_cx, r_cy, r_ax, r_ay, r_sx, r_sy);
   assign w_ge0   = !w_e0[PW-1] && !w_e1[PW-1] && !w_e2[PW-1];
   assign w_le0   = (w_e0[PW-1] || (w_e0 == '0)) &&
                    (w_e1[PW-1] || (w_e1 == '0)) &&
                    (w_e2[PW-1] || (w_e2 == '0));
   // The sign of D gives the winding. Points on an edge count as inside for either winding.
   assign w_inside = (r_d != '0) && (r_d[PW-1] ? w_le0 : w_ge0);
   assign w_last   = (r_sx == r_xmax) && (r_sy == r_ymax);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= c_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic. nt is only looked at while idle.
   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE:   if (bus.nt) w_next = c_LOAD_B;
         c_LOAD_B: w_next = c_LOAD_C;
         c_LOAD_C: w_next = c_SETUP;
         c_SETUP:  w_next = w_degen ? c_IDLE : c_SCAN;
         c_SCAN:   if (w_last) w_next = c_DRAIN;
         c_DRAIN:  w_next = c_IDLE;
         default:  w_next = c_IDLE;
      endcase
   end

   // Decode the state into datapath strobes
   always_comb begin
      w_ld_a  = 1'b0;
      w_ld_b  = 1'b0;
      w_ld_c  = 1'b0;
      w_setup = 1'b0;
      w_scan  = 1'b0;
      w_drain = 1'b0;
      case (r_state)
         c_IDLE:   w_ld_a  = bus.nt;
         c_LOAD_B: w_ld_b  = 1'b1;
         c_LOAD_C: w_ld_c  = 1'b1;
         c_SETUP:  w_setup = 1'b1;
         c_SCAN:   w_scan  = 1'b1;
         c_DRAIN:  w_drain = 1'b1;
         default:  ;
      endcase
   end

   // Capture the three vertices on consecutive cycles
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ax <= '0; r_ay <= '0;
         r_bx <= '0; r_by <= '0;
         r_cx <= '0; r_cy <= '0;
      end else begin
         if (w_ld_a) begin r_ax <= bus.xi; r_ay <= bus.yi; end
         if (w_ld_b) begin r_bx <= bus.xi; r_by <= bus.yi; end
         if (w_ld_c) begin r_cx <= bus.xi; r_cy <= bus.yi; end
      end
   end

   // Latch the bounding box and the doubled signed area once per triangle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_xmin <= '0; r_xmax <= '0;
         r_ymin <= '0; r_ymax <= '0;
         r_d    <= '0;
      end else if (w_setup) begin
         r_xmin <= w_xmin; r_xmax <= w_xmax;
         r_ymin <= w_ymin; r_ymax <= w_ymax;
         r_d    <= w_d;
      end
   end

   // Raster counters. Each compare happens before the increment, so the counters never wrap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sx <= '0;
         r_sy <= '0;
      end else if (w_setup && !w_degen) begin
         r_sx <= w_xmin;
         r_sy <= w_ymin;
      end else if (w_scan) begin
         if (r_sx == r_xmax) begin
            r_sx <= r_xmin;
            if (r_sy != r_ymax) r_sy <= r_sy + c_ONE;
         end else begin
            r_sx <= r_sx + c_ONE;
         end
      end
   end

   // Registered outputs. Each point appears one cycle after it is evaluated.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_busy <= 1'b0;
         r_po   <= 1'b0;
         r_xo   <= '0;
         r_yo   <= '0;
      end else begin
         if (w_ld_c)                          r_busy <= 1'b1;
         else if ((w_setup && w_degen) || w_drain) r_busy <= 1'b0;
         r_po <= w_scan && w_inside;
         if (w_scan) begin
            r_xo <= r_sx;
            r_yo <= r_sy;
         end
      end
   end

   assign bus.busy = r_busy;
   assign bus.po   = r_po;
   assign bus.xo   = r_xo;
   assign bus.yo   = r_yo;
endmodule
`default_nettype wire

// File: tb/tb_tri_raster_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_tri_raster_scan
// Description : Self-checking bench for tri_raster_scan. An integer-arithmetic
//               reference model predicts every output slot.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tri_raster_scan;
   localparam int CW = 3;

   logic clk = 1'b0;
   logic reset;
   int   n_err = 0;
   int   n_chk = 0;

   tri_raster_scan_if #(.CW(CW)) bus ();
   tri_raster_scan #(.CW(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   function automatic int f_cross(input int ax, input int ay, input int bx,
                                  input int by, input int px, input int py);
      return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
   endfunction

   // Drive one triangle, starting at a falling edge, and check every slot until busy drops.
   task automatic run_tri(input int ax, input int ay, input int bx, input int by,
                          input int cx, input int cy, input int junk_at,
                          output int npulse, output int lx, output int ly);
      int xs[$];
      int ys[$];
      bit ins[$];
      int xmin, xmax, ymin, ymax, d, nb, e0, e1, e2;
      bit exp_po;
      xmin = (ax < bx) ? ax : bx; xmin = (cx < xmin) ? cx : xmin;
      xmax = (ax > bx) ? ax : bx; xmax = (cx > xmax) ? cx : xmax;
      ymin = (ay < by) ? ay : by; ymin = (cy < ymin) ? cy : ymin;
      ymax = (ay > by) ? ay : by; ymax = (cy > ymax) ? cy : ymax;
      d = f_cross(ax, ay, bx, by, cx, cy);
      for (int y = ymin; y <= ymax; y++) begin
         for (int x = xmin; x <= xmax; x++) begin
            e0 = f_cross(ax, ay, bx, by, x, y);
            e1 = f_cross(bx, by, cx, cy, x, y);
            e2 = f_cross(cx, cy, ax, ay, x, y);
            xs.push_back(x);
            ys.push_back(y);
            ins.push_back((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0));
         end
      end
      nb = (d == 0) ? 1 : xs.size() + 2;
      npulse = 0; lx = -1; ly = -1;

      bus.nt = 1'b1; bus.xi = CW'(ax); bus.yi = CW'(ay);
      @(negedge clk);
      n_chk++;
      if (bus.busy !== 1'b0 || bus.po !== 1'b0) begin
         n_err++;
         $display("FAIL load_b busy/po got=%b%b expected=00", bus.busy, bus.po);
      end
      bus.nt = 1'b0; bus.xi = CW'(bx); bus.yi = CW'(by);
      @(negedge clk);
      n_chk++;
      if (bus.busy !== 1'b0 || bus.po !== 1'b0) begin
         n_err++;
         $display("FAIL load_c busy/po got=%b%b expected=00", bus.busy, bus.po);
      end
      bus.xi = CW'(cx); bus.yi = CW'(cy);
      @(negedge clk);
      for (int j = 0; j < nb; j++) begin
         exp_po = (j >= 2) ? ins[j-2] : 1'b0;
         n_chk++;
         if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy slot=%0d got=%b expected=1", j, bus.busy);
         end
         n_chk++;
         if (bus.po !== exp_po) begin
            n_err++;
            $display("FAIL po slot=%0d got=%b expected=%b", j, bus.po, exp_po);
         end
         if (j >= 2) begin
            n_chk++;
            if (bus.xo !== CW'(xs[j-2]) || bus.yo !== CW'(ys[j-2])) begin
               n_err++;
               $display("FAIL xy slot=%0d got=(%0d,%0d) expected=(%0d,%0d)",
                        j, bus.xo, bus.yo, xs[j-2], ys[j-2]);
            end
         end
         if (bus.po === 1'b1) begin
            npulse++;
            lx = int'(bus.xo);
            ly = int'(bus.yo);
         end
         if (junk_at >= 0 && j >= junk_at && j < junk_at + 3) begin
            bus.nt = 1'b1; bus.xi = CW'($urandom); bus.yi = CW'($urandom);
         end else begin
            bus.nt = 1'b0;
         end
         @(negedge clk);
      end
      bus.nt = 1'b0;
      n_chk++;
      if (bus.busy !== 1'b0 || bus.po !== 1'b0) begin
         n_err++;
         $display("FAIL end busy/po got=%b%b expected=00", bus.busy, bus.po);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; bus.nt = 1'b0; bus.xi = '0; bus.yi = '0;
      repeat (2) @(negedge clk);
      n_chk++;
      if ({bus.busy, bus.po, bus.xo, bus.yo} !== '0) begin
         n_err++;
         $display("FAIL reset outputs got=%b%b %0d %0d expected=0", bus.busy, bus.po, bus.xo, bus.yo);
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++;
      if (bus.busy !== 1'b0 || bus.po !== 1'b0) begin
         n_err++;
         $display("FAIL idle_nt0 busy/po got=%b%b expected=00", bus.busy, bus.po);
      end
   endtask

   task automatic test_basic();
      int np, lx, ly;
      run_tri(0, 0, 3, 0, 0, 3, -1, np, lx, ly);
      n_chk++;
      if (np != 10 || lx != 0 || ly != 3) begin
         n_err++;
         $display("FAIL basic pulses=%0d last=(%0d,%0d) expected 10 (0,3)", np, lx, ly);
      end
      run_tri(0, 0, 0, 3, 3, 0, -1, np, lx, ly);
      n_chk++;
      if (np != 10 || lx != 0 || ly != 3) begin
         n_err++;
         $display("FAIL reversed pulses=%0d last=(%0d,%0d) expected 10 (0,3)", np, lx, ly);
      end
   endtask

   task automatic test_degenerate();
      int np, lx, ly;
      run_tri(0, 0, 2, 2, 4, 4, -1, np, lx, ly);
      n_chk++;
      if (np != 0) begin
         n_err++;
         $display("FAIL collinear pulses got=%0d expected=0", np);
      end
      run_tri(5, 5, 5, 5, 5, 5, -1, np, lx, ly);
      n_chk++;
      if (np != 0) begin
         n_err++;
         $display("FAIL coincident pulses got=%0d expected=0", np);
      end
   endtask

   task automatic test_full_range();
      int np, lx, ly;
      run_tri(0, 0, 7, 0, 0, 7, -1, np, lx, ly);
      n_chk++;
      if (np != 36 || lx != 0 || ly != 7) begin
         n_err++;
         $display("FAIL full pulses=%0d last=(%0d,%0d) expected 36 (0,7)", np, lx, ly);
      end
   endtask

   task automatic test_back_to_back();
      int np, lx, ly;
      run_tri(0, 0, 7, 0, 0, 7, 20, np, lx, ly);
      n_chk++;
      if (np != 36) begin
         n_err++;
         $display("FAIL junk_nt pulses got=%0d expected=36", np);
      end
      run_tri(2, 2, 4, 2, 2, 4, -1, np, lx, ly);
      n_chk++;
      if (np != 6 || lx != 2 || ly != 4) begin
         n_err++;
         $display("FAIL b2b pulses=%0d last=(%0d,%0d) expected 6 (2,4)", np, lx, ly);
      end
   endtask

   task automatic test_async_reset();
      int np, lx, ly;
      bus.nt = 1'b1; bus.xi = 3'd0; bus.yi = 3'd0;
      @(negedge clk); bus.nt = 1'b0; bus.xi = 3'd7; bus.yi = 3'd0;
      @(negedge clk); bus.xi = 3'd0; bus.yi = 3'd7;
      @(negedge clk);
      repeat (4) @(negedge clk);
      n_chk++;
      if (bus.po !== 1'b1 || bus.xo !== 3'd2 || bus.yo !== 3'd0) begin
         n_err++;
         $display("FAIL prereset po=%b xy=(%0d,%0d) expected 1 (2,0)", bus.po, bus.xo, bus.yo);
      end
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      n_chk++;
      if ({bus.busy, bus.po, bus.xo, bus.yo} !== '0) begin
         n_err++;
         $display("FAIL async_reset got=%b%b %0d %0d expected=0", bus.busy, bus.po, bus.xo, bus.yo);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      run_tri(1, 6, 6, 1, 1, 1, -1, np, lx, ly);
   endtask

   task automatic test_random();
      int np, lx, ly;
      for (int t = 0; t < 25; t++) begin
         run_tri($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 80), np, lx, ly);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_degenerate();
      test_full_range();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end
endmodule
`default_nettype wire
